// File: rtl/vga_timing_gen_pkg.sv
// Shared types and constants for the VGA raster timing generator.
// Holds the per-axis phase enum, the default 800x600@72 Hz mode
// (50 MHz pixel clock) and the fixed counter widths.
package vga_timing_pkg;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 56;
  localparam int DEF_H_SYNC   = 120;
  localparam int DEF_H_BP     = 64;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 37;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 23;

  localparam bit DEF_H_SYNC_POL = 1'b1;
  localparam bit DEF_V_SYNC_POL = 1'b1;

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } phase_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle between the timing generator (master) and the
// colour stage / connector pins (slave).
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic [HCOUNT_W-1:0] hcount;
  logic [VCOUNT_W-1:0] vcount;
  logic                display_on;
  logic                hsync;
  logic                vsync;
  logic                line_start;
  logic                frame_start;

  modport master (
    output hcount, vcount, display_on, hsync, vsync, line_start, frame_start
  );

  modport slave (
    input hcount, vcount, display_on, hsync, vsync, line_start, frame_start
  );

endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: a position counter plus its ACTIVE/FRONT/SYNC/BACK
// phase FSM. The counter steps only when 'advance' is high and wraps
// after the back porch. 'phase_nxt' is the phase that will hold after
// the coming edge, so the parent can register decoded outputs that line
// up with the registered count. 'wrap' flags that this edge returns the
// count to 0.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_LEN = 800,
  parameter int FP_LEN     = 56,
  parameter int SYNC_LEN   = 120,
  parameter int BP_LEN     = 64,
  parameter int WIDTH      = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [WIDTH-1:0] count,
  output phase_t           phase_nxt,
  output logic             wrap
);

  localparam int TOTAL = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN;

  localparam logic [WIDTH-1:0] LAST     = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] FRONT_AT = WIDTH'(ACTIVE_LEN);
  localparam logic [WIDTH-1:0] SYNC_AT  = WIDTH'(ACTIVE_LEN + FP_LEN);
  localparam logic [WIDTH-1:0] BACK_AT  = WIDTH'(ACTIVE_LEN + FP_LEN + SYNC_LEN);

  phase_t           phase;
  logic [WIDTH-1:0] count_nxt;

  assign wrap = advance && (count == LAST);

  // Next count and phase: phases change exactly where the new count crosses a boundary
  always_comb begin
    count_nxt = count;
    phase_nxt = phase;
    if (advance) begin
      if (count == LAST) begin
        count_nxt = '0;
        phase_nxt = ACTIVE;
      end else begin
        count_nxt = count + 1'b1;
        case (count_nxt)
          FRONT_AT: phase_nxt = FRONT;
          SYNC_AT:  phase_nxt = SYNC;
          BACK_AT:  phase_nxt = BACK;
          default:  phase_nxt = phase;
        endcase
      end
    end
  end

  // Counter/phase registers; reset parks the axis on its last back-porch position
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= LAST;
      phase <= BACK;
    end else begin
      count <= count_nxt;
      phase <= phase_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (default 800x600@72 Hz, 50 MHz pixel clock).
// Produces pixel position, display_on, hsync/vsync and line/frame start
// strobes, all registered and describing the same position each cycle.
// Optional build macro VGA_PIX_CE_EN adds a pix_ce pixel-enable input;
// without it the generator advances on every clk.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit H_SYNC_POL = DEF_H_SYNC_POL,
  parameter bit V_SYNC_POL = DEF_V_SYNC_POL
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
`ifdef VGA_PIX_CE_EN
  ,
  input  logic             pix_ce
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL must be <= 2048 and V_TOTAL <= 1024");
  end
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
    $error("vga_timing_gen: every porch/sync/active length must be non-zero");
  end

  logic                adv;
  logic [HCOUNT_W-1:0] h_count;
  logic [VCOUNT_W-1:0] v_count;
  phase_t              h_phase_nxt;
  phase_t              v_phase_nxt;
  logic                h_wrap;
  logic                v_wrap;

  logic display_on_q;
  logic hsync_q;
  logic vsync_q;
  logic line_start_q;
  logic frame_start_q;

`ifdef VGA_PIX_CE_EN
  assign adv = pix_ce;
`else
  assign adv = 1'b1;
`endif

  vga_axis_counter #(
    .ACTIVE_LEN (H_ACTIVE),
    .FP_LEN     (H_FP),
    .SYNC_LEN   (H_SYNC),
    .BP_LEN     (H_BP),
    .WIDTH      (HCOUNT_W)
  ) u_h_axis (
    .clk       (clk),
    .rst       (rst),
    .advance   (adv),
    .count     (h_count),
    .phase_nxt (h_phase_nxt),
    .wrap      (h_wrap)
  );

  // The vertical axis steps once per line, on the edge the horizontal count wraps
  vga_axis_counter #(
    .ACTIVE_LEN (V_ACTIVE),
    .FP_LEN     (V_FP),
    .SYNC_LEN   (V_SYNC),
    .BP_LEN     (V_BP),
    .WIDTH      (VCOUNT_W)
  ) u_v_axis (
    .clk       (clk),
    .rst       (rst),
    .advance   (h_wrap),
    .count     (v_count),
    .phase_nxt (v_phase_nxt),
    .wrap      (v_wrap)
  );

  // Registered decodes of the upcoming phases, so they align with the registered counters
  always_ff @(posedge clk) begin
    if (rst) begin
      display_on_q  <= 1'b0;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (adv) begin
      display_on_q  <= (h_phase_nxt == ACTIVE) && (v_phase_nxt == ACTIVE);
      hsync_q       <= (h_phase_nxt == SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_q       <= (v_phase_nxt == SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
      line_start_q  <= h_wrap;
      frame_start_q <= h_wrap && v_wrap;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign vga.hcount      = h_count;
  assign vga.vcount      = v_count;
  assign vga.display_on  = display_on_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen. Two instances share clk/rst
// (and pix_ce when VGA_PIX_CE_EN is defined): the default 800x600 mode,
// and a tiny mode with inverted sync polarity so whole frames fit in a
// short run. A position-based reference model predicts every output.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int S_HA = 16, S_HF = 3, S_HS = 5, S_HB = 4;
  localparam int S_VA = 10, S_VF = 2, S_VS = 3, S_VB = 2;
  localparam bit S_HPOL = 1'b0, S_VPOL = 1'b0;

  logic clk = 1'b0;
  logic rst;
  logic ce_drv;

  int n_checks = 0;
  int n_fail   = 0;

  int cfg_ha[2], cfg_hf[2], cfg_hs[2], cfg_hb[2];
  int cfg_va[2], cfg_vf[2], cfg_vs[2], cfg_vb[2];
  bit cfg_hpol[2], cfg_vpol[2];

  int m_h[2], m_v[2];
  bit m_ls[2], m_fs[2];

  always #5 clk = ~clk;

  vga_timing_gen_if vif_def ();
  vga_timing_gen_if vif_sml ();

  vga_timing_gen u_def (
    .clk (clk),
    .rst (rst),
    .vga (vif_def)
`ifdef VGA_PIX_CE_EN
    ,
    .pix_ce (ce_drv)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
    .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
    .H_SYNC_POL (S_HPOL), .V_SYNC_POL (S_VPOL)
  ) u_sml (
    .clk (clk),
    .rst (rst),
    .vga (vif_sml)
`ifdef VGA_PIX_CE_EN
    ,
    .pix_ce (ce_drv)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
    n_checks++;
    if (observed !== 32'(expected)) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Reference: advance the pixel position the way a raster scan walks the screen
  task automatic modelStep(input int i, input bit r, input bit ce);
    int ht;
    int vt;
    ht = cfg_ha[i] + cfg_hf[i] + cfg_hs[i] + cfg_hb[i];
    vt = cfg_va[i] + cfg_vf[i] + cfg_vs[i] + cfg_vb[i];
    m_ls[i] = 1'b0;
    m_fs[i] = 1'b0;
    if (r) begin
      m_h[i] = ht - 1;
      m_v[i] = vt - 1;
    end else if (ce) begin
      m_h[i] = m_h[i] + 1;
      if (m_h[i] == ht) begin
        m_h[i] = 0;
        m_v[i] = (m_v[i] + 1 == vt) ? 0 : m_v[i] + 1;
        m_ls[i] = 1'b1;
        m_fs[i] = (m_v[i] == 0);
      end
    end
  endtask

  task automatic compareInst(input int i, input logic [10:0] hc, input logic [9:0] vc,
                             input logic d, input logic hs, input logic vs,
                             input logic ls, input logic fs);
    string nm;
    bit    vis;
    bit    in_hs;
    bit    in_vs;
    nm    = (i == 0) ? "def" : "sml";
    vis   = (m_h[i] < cfg_ha[i]) && (m_v[i] < cfg_va[i]);
    in_hs = (m_h[i] >= cfg_ha[i] + cfg_hf[i]) && (m_h[i] < cfg_ha[i] + cfg_hf[i] + cfg_hs[i]);
    in_vs = (m_v[i] >= cfg_va[i] + cfg_vf[i]) && (m_v[i] < cfg_va[i] + cfg_vf[i] + cfg_vs[i]);
    checkOutput({nm, ".hcount"},      32'(hc), m_h[i]);
    checkOutput({nm, ".vcount"},      32'(vc), m_v[i]);
    checkOutput({nm, ".display_on"},  32'(d),  int'(vis));
    checkOutput({nm, ".hsync"},       32'(hs), int'(in_hs ? cfg_hpol[i] : !cfg_hpol[i]));
    checkOutput({nm, ".vsync"},       32'(vs), int'(in_vs ? cfg_vpol[i] : !cfg_vpol[i]));
    checkOutput({nm, ".line_start"},  32'(ls), int'(m_ls[i]));
    checkOutput({nm, ".frame_start"}, 32'(fs), int'(m_fs[i]));
  endtask

  // Drive one cycle of inputs, predict it, then check both instances on the falling edge
  task automatic applyStimulus(input bit r, input bit ce);
    bit eff_ce;
`ifdef VGA_PIX_CE_EN
    eff_ce = ce;
`else
    eff_ce = 1'b1;
`endif
    rst    = r;
    ce_drv = ce;
    modelStep(0, r, eff_ce);
    modelStep(1, r, eff_ce);
    @(negedge clk);
    compareInst(0, vif_def.hcount, vif_def.vcount, vif_def.display_on, vif_def.hsync,
                vif_def.vsync, vif_def.line_start, vif_def.frame_start);
    compareInst(1, vif_sml.hcount, vif_sml.vcount, vif_sml.display_on, vif_sml.hsync,
                vif_sml.vsync, vif_sml.line_start, vif_sml.frame_start);
  endtask

  initial begin
    cfg_ha = '{800, S_HA}; cfg_hf = '{56, S_HF}; cfg_hs = '{120, S_HS}; cfg_hb = '{64, S_HB};
    cfg_va = '{600, S_VA}; cfg_vf = '{37, S_VF}; cfg_vs = '{6, S_VS};   cfg_vb = '{23, S_VB};
    cfg_hpol = '{1'b1, S_HPOL};
    cfg_vpol = '{1'b1, S_VPOL};
    rst    = 1'b1;
    ce_drv = 1'b1;

    $display("[TB] reset hold and release");
    repeat (3) applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);

    $display("[TB] free run over several default-mode lines");
    for (int k = 0; k < 6400; k++) applyStimulus(1'b0, 1'b1);

    $display("[TB] pixel enable toggling");
    for (int k = 0; k < 80; k++) applyStimulus(1'b0, (k % 2) == 0);

    $display("[TB] mid-frame reset pulse");
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);

    $display("[TB] randomized enable and occasional reset");
    for (int k = 0; k < 6000; k++) begin
      applyStimulus($urandom_range(0, 2499) == 0, $urandom_range(0, 3) != 0);
    end

    $display("[TB] reset while pixel enable is low");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    for (int k = 0; k < 1200; k++) applyStimulus(1'b0, $urandom_range(0, 1) == 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
